// File: rtl/div_unit_pkg.sv
// Shared constants, state encoding and operand helper for the execute-stage divider.
package div_unit_pkg;

  localparam int DATA_WIDTH      = 32;
  localparam int DoubleDataWidth = 2 * DATA_WIDTH;
  localparam int CntWidth        = $clog2(DATA_WIDTH + 1);

  localparam logic [CntWidth-1:0] CntLast = CntWidth'(DATA_WIDTH);

  localparam logic DivResultReady    = 1'b1;
  localparam logic DivResultNotReady = 1'b0;
  localparam logic DivStart          = 1'b1;
  localparam logic DivStop           = 1'b0;

  typedef enum logic [1:0] {
    DivFree   = 2'b00,
    DivByZero = 2'b01,
    DivOn     = 2'b10,
    DivEnd    = 2'b11
  } div_state_e;

  // Two's-complement magnitude; 0x80000000 stays 0x80000000 and is read as unsigned.
  function automatic logic [DATA_WIDTH-1:0] magnitude(input logic [DATA_WIDTH-1:0] value,
                                                      input logic is_signed);
    return (is_signed && value[DATA_WIDTH-1]) ? -value : value;
  endfunction

endpackage

// File: rtl/div_unit_if.sv
// Request/response bundle between the EX stage (master) and the divider (slave).
import div_unit_pkg::*;

interface div_unit_if;
  logic                         start_i;
  logic                         annul_i;
  logic                         signed_div_i;
  logic [DATA_WIDTH-1:0]        opdata1_i;
  logic [DATA_WIDTH-1:0]        opdata2_i;
  logic [DoubleDataWidth-1:0]   result_o;
  logic                         ready_o;

  modport master (
    output start_i, annul_i, signed_div_i, opdata1_i, opdata2_i,
    input  result_o, ready_o
  );

  modport slave (
    input  start_i, annul_i, signed_div_i, opdata1_i, opdata2_i,
    output result_o, ready_o
  );
endinterface

// File: rtl/div_unit.sv
// Restoring divider, one quotient bit per cycle, result {remainder, quotient}.
// Signed DIV support is compiled in only when DIV_SIGNED_EN is defined.
module div_unit
  import div_unit_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  div_unit_if.slave  div_bus
);

  div_state_e                 state, next_state;
  logic [DoubleDataWidth:0]   dvd;
  logic [DATA_WIDTH-1:0]      dvs;
  logic [CntWidth-1:0]        cnt;
  logic [DATA_WIDTH-1:0]      tmp;
  logic                       borrow;
  logic                       accept;
  logic                       divisor_zero;
  logic [DATA_WIDTH-1:0]      op1_mag, op2_mag;
  logic [DATA_WIDTH-1:0]      quot_fix, rem_fix;

`ifdef DIV_SIGNED_EN
  logic quot_neg, rem_neg;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) state <= DivFree;
    else        state <= next_state;
  end

  // Trial subtraction looks at the partial remainder as it would be after the shift,
  // keeping the carry-out bit so divisors near 2^W are still handled.
  always_comb begin
    accept       = (div_bus.start_i == DivStart) && !div_bus.annul_i;
    divisor_zero = (div_bus.opdata2_i == '0);
    borrow       = dvd[DoubleDataWidth:DATA_WIDTH] < {1'b0, dvs};
    tmp          = dvd[DoubleDataWidth-1:DATA_WIDTH] - dvs;
`ifdef DIV_SIGNED_EN
    op1_mag  = magnitude(div_bus.opdata1_i, div_bus.signed_div_i);
    op2_mag  = magnitude(div_bus.opdata2_i, div_bus.signed_div_i);
    quot_fix = quot_neg ? -dvd[DATA_WIDTH-1:0] : dvd[DATA_WIDTH-1:0];
    rem_fix  = rem_neg ? -dvd[DoubleDataWidth:DATA_WIDTH+1] : dvd[DoubleDataWidth:DATA_WIDTH+1];
`else
    op1_mag  = div_bus.opdata1_i;
    op2_mag  = div_bus.opdata2_i;
    quot_fix = dvd[DATA_WIDTH-1:0];
    rem_fix  = dvd[DoubleDataWidth:DATA_WIDTH+1];
`endif

    next_state = state;
    case (state)
      DivFree:   if (accept) next_state = divisor_zero ? DivByZero : DivOn;
      DivByZero: next_state = DivEnd;
      DivOn: begin
        if (div_bus.annul_i)     next_state = DivFree;
        else if (cnt == CntLast) next_state = DivEnd;
      end
      DivEnd:    if (div_bus.start_i == DivStop) next_state = DivFree;
      default:   next_state = DivFree;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dvd             <= '0;
      dvs             <= '0;
      cnt             <= '0;
      div_bus.result_o <= '0;
      div_bus.ready_o  <= DivResultNotReady;
`ifdef DIV_SIGNED_EN
      quot_neg        <= 1'b0;
      rem_neg         <= 1'b0;
`endif
    end else begin
      case (state)
        DivFree: begin
          div_bus.result_o <= '0;
          div_bus.ready_o  <= DivResultNotReady;
          if (accept && !divisor_zero) begin
            dvd <= {{DATA_WIDTH{1'b0}}, op1_mag, 1'b0};
            dvs <= op2_mag;
            cnt <= '0;
`ifdef DIV_SIGNED_EN
            quot_neg <= div_bus.signed_div_i &&
                        (div_bus.opdata1_i[DATA_WIDTH-1] ^ div_bus.opdata2_i[DATA_WIDTH-1]);
            rem_neg  <= div_bus.signed_div_i && div_bus.opdata1_i[DATA_WIDTH-1];
`endif
          end
        end
        DivByZero: begin
          div_bus.result_o <= '0;
          div_bus.ready_o  <= DivResultReady;
        end
        DivOn: begin
          if (div_bus.annul_i) begin
            div_bus.result_o <= '0;
            div_bus.ready_o  <= DivResultNotReady;
          end else if (cnt != CntLast) begin
            if (borrow) dvd <= {dvd[DoubleDataWidth-1:0], 1'b0};
            else        dvd <= {tmp, dvd[DATA_WIDTH-1:0], 1'b1};
            cnt <= cnt + 1'b1;
          end else begin
            div_bus.result_o <= {rem_fix, quot_fix};
            div_bus.ready_o  <= DivResultReady;
          end
        end
        DivEnd: begin
          if (div_bus.start_i == DivStart) begin
            div_bus.ready_o <= DivResultReady;
          end else begin
            div_bus.result_o <= '0;
            div_bus.ready_o  <= DivResultNotReady;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
